// File: rtl/hash_search_ctrl_if.sv
// Handshake between the search controller and the hash core.
// The controller drives start/nonce (master); the core answers with done/digest (slave).
interface hash_search_ctrl_if #(
    parameter int NONCE_W  = 32,
    parameter int DIGEST_W = 32
);
    logic                core_start;
    logic [NONCE_W-1:0]  core_nonce;
    logic                core_done;
    logic [DIGEST_W-1:0] core_digest;

    modport master (output core_start, core_nonce, input core_done, core_digest);
    modport slave  (input core_start, core_nonce, output core_done, core_digest);
endinterface

// File: rtl/hash_search_ctrl.sv
// Nonce search sequencer: issues candidates to a hash core until a digest matches target.
// Optional core watchdog and timeout_err output enabled by defining HASH_SEARCH_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no search, waiting for cmd_start
// WAIT_LOCK | search active, waiting for the core clock to be valid
// ISSUE     | launch the current nonce (core_start follows next cycle)
// WAIT_DONE | waiting for core_done
// CHECK     | compare registered digest, advance or finish
// FOUND     | match recorded; behaves as IDLE for cmd_start
// EXHAUSTED | no candidate matched; behaves as IDLE for cmd_start
module hash_search_ctrl #(
    parameter int NONCE_W        = 32,
    parameter int DIGEST_W       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                pll_locked,
    input  logic                cmd_start,
    input  logic                cmd_abort,
    input  logic [NONCE_W-1:0]  nonce_base,
    input  logic [NONCE_W-1:0]  nonce_count,
    input  logic [DIGEST_W-1:0] target,
    hash_search_ctrl_if.master  core,
    output logic                busy,
    output logic                found,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic                exhausted,
    output logic [4:0]          status_led
`ifdef HASH_SEARCH_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    typedef enum logic [2:0] {
        IDLE, WAIT_LOCK, ISSUE, WAIT_DONE, CHECK, FOUND, EXHAUSTED
    } state_t;

    state_t              state;
    logic [NONCE_W-1:0]  nonce;
    logic [NONCE_W-1:0]  remaining;
    logic [DIGEST_W-1:0] target_q;
    logic [DIGEST_W-1:0] digest_q;
    logic [24:0]         hb_cnt;

`ifdef HASH_SEARCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign core.core_nonce = nonce;
    assign status_led      = {pll_locked, exhausted, found, busy, hb_cnt[24]};

    always_ff @(posedge clk_50) begin
        if (reset) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 25'd1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state           <= IDLE;
            core.core_start <= 1'b0;
            nonce           <= '0;
            remaining       <= '0;
            target_q        <= '0;
            digest_q        <= '0;
            busy            <= 1'b0;
            found           <= 1'b0;
            found_nonce     <= '0;
            exhausted       <= 1'b0;
`ifdef HASH_SEARCH_TIMEOUT_EN
            wd_cnt          <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            core.core_start <= 1'b0;
            // Abort wins over everything, including a matching result in the same cycle.
            if (cmd_abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, FOUND, EXHAUSTED: begin
                        if (cmd_start) begin
                            nonce     <= nonce_base;
                            remaining <= nonce_count;
                            target_q  <= target;
                            found     <= 1'b0;
                            exhausted <= 1'b0;
                            busy      <= 1'b1;
                            state     <= WAIT_LOCK;
`ifdef HASH_SEARCH_TIMEOUT_EN
                            timeout_err <= 1'b0;
`endif
                        end
                    end
                    WAIT_LOCK: begin
                        if (remaining == '0) begin
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= EXHAUSTED;
                        end else if (pll_locked) begin
                            state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (!pll_locked) begin
                            state <= WAIT_LOCK;
                        end else begin
                            core.core_start <= 1'b1;
                            state           <= WAIT_DONE;
`ifdef HASH_SEARCH_TIMEOUT_EN
                            wd_cnt          <= WD_W'(TIMEOUT_CYCLES);
`endif
                        end
                    end
                    WAIT_DONE: begin
                        if (!pll_locked) begin
                            state <= WAIT_LOCK;
                        end else if (core.core_done) begin
                            digest_q <= core.core_digest;
                            state    <= CHECK;
                        end
`ifdef HASH_SEARCH_TIMEOUT_EN
                        else if (wd_cnt == '0) begin
                            timeout_err <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            wd_cnt <= wd_cnt - 1'b1;
                        end
`endif
                    end
                    CHECK: begin
                        if (!pll_locked) begin
                            state <= WAIT_LOCK;
                        end else if (digest_q == target_q) begin
                            found       <= 1'b1;
                            found_nonce <= nonce;
                            busy        <= 1'b0;
                            state       <= FOUND;
                        end else if (remaining == NONCE_W'(1)) begin
                            remaining <= '0;
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= EXHAUSTED;
                        end else begin
                            remaining <= remaining - 1'b1;
                            nonce     <= nonce + 1'b1;
                            state     <= ISSUE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hash_search_ctrl.sv
// Self-checking bench for hash_search_ctrl: behavioural hash core plus a nonce scoreboard.
// Define HASH_SEARCH_TIMEOUT_EN to also exercise the core watchdog.
module tb_hash_search_ctrl;

    localparam int LAT = 4;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        pll_locked;
    logic        cmd_start;
    logic        cmd_abort;
    logic [31:0] nonce_base;
    logic [31:0] nonce_count;
    logic [31:0] target;
    logic        busy;
    logic        found;
    logic [31:0] found_nonce;
    logic        exhausted;
    logic [4:0]  status_led;
`ifdef HASH_SEARCH_TIMEOUT_EN
    logic        timeout_err;
`endif

    hash_search_ctrl_if #(.NONCE_W(32), .DIGEST_W(32)) bus ();

    hash_search_ctrl #(.NONCE_W(32), .DIGEST_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .cmd_start   (cmd_start),
        .cmd_abort   (cmd_abort),
        .nonce_base  (nonce_base),
        .nonce_count (nonce_count),
        .target      (target),
        .core        (bus),
        .busy        (busy),
        .found       (found),
        .found_nonce (found_nonce),
        .exhausted   (exhausted),
        .status_led  (status_led)
`ifdef HASH_SEARCH_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #10 clk_50 = ~clk_50;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cycle    = 0;
    logic [31:0] exp_q[$];
    int          start_log[$];

    // behavioural core state
    bit          core_alive  = 1'b1;
    bit          pend        = 1'b0;
    int          lat_left    = 0;
    int          lat_cfg     = LAT;
    logic [31:0] hold_nonce  = '0;
    logic [31:0] match_nonce = '0;
    logic [31:0] cur_target  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: core model answers, scoreboard consumes any core_start.
    task automatic step();
        @(negedge clk_50);
        cycle++;
        bus.core_done = 1'b0;
        if (pend) begin
            lat_left--;
            if (lat_left == 0) begin
                pend            = 1'b0;
                bus.core_done   = 1'b1;
                bus.core_digest = (hold_nonce == match_nonce) ? cur_target : ~cur_target;
            end
        end
        if (bus.core_start) begin
            start_log.push_back(cycle);
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("core_nonce", bus.core_nonce, exp_q.pop_front());
            if (core_alive) begin
                pend       = 1'b1;
                lat_left   = lat_cfg;
                hold_nonce = bus.core_nonce;
            end
        end
    endtask

    task automatic do_start(input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] tgt);
        nonce_base  = base;
        nonce_count = cnt;
        target      = tgt;
        cur_target  = tgt;
        cmd_start   = 1'b1;
        step();
        cmd_start   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        check("idle_in_budget", 32'(busy), 32'd0);
    endtask

    task automatic wait_starts(input int total, input int max_cyc);
        int n = 0;
        while (start_log.size() < total && n < max_cyc) begin
            step();
            n++;
        end
        check("starts_in_budget", 32'(start_log.size()), 32'(total));
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0;
        reset           = 1'b1;
        pll_locked      = 1'b1;
        cmd_start       = 1'b0;
        cmd_abort       = 1'b0;
        nonce_base      = '0;
        nonce_count     = '0;
        target          = '0;
        bus.core_done   = 1'b0;
        bus.core_digest = '0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_exhausted", 32'(exhausted), 32'd0);
        check("rst_core_start", 32'(bus.core_start), 32'd0);
        check("rst_core_nonce", bus.core_nonce, 32'd0);
        check("rst_found_nonce", found_nonce, 32'd0);
        check("rst_status_led", 32'(status_led), 32'b10000);
        reset = 1'b0;
        step();

        // match at 0x12 out of four candidates from 0x10
        match_nonce = 32'h12;
        s0 = start_log.size();
        exp_q.push_back(32'h10); exp_q.push_back(32'h11); exp_q.push_back(32'h12);
        do_start(32'h10, 32'd4, 32'hA5A5_1234);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_idle(200);
        check("m_found", 32'(found), 32'd1);
        check("m_found_nonce", found_nonce, 32'h12);
        check("m_exhausted", 32'(exhausted), 32'd0);
        check("m_starts", 32'(start_log.size() - s0), 32'd3);
        for (int i = s0 + 1; i < start_log.size(); i++)
            check("m_issue_gap", 32'(start_log[i] - start_log[i-1]), 32'(LAT + 3));
        check("m_status_led", 32'(status_led), 32'b10100);
        check("m_sb_drained", 32'(exp_q.size()), 32'd0);

        // wrap across all-ones, no match
        match_nonce = 32'h5555_0000;
        s0 = start_log.size();
        exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
        do_start(32'hFFFF_FFFE, 32'd3, 32'h0BAD_F00D);
        check("w_found_cleared", 32'(found), 32'd0);
        wait_idle(200);
        check("w_exhausted", 32'(exhausted), 32'd1);
        check("w_found", 32'(found), 32'd0);
        check("w_starts", 32'(start_log.size() - s0), 32'd3);
        check("w_sb_drained", 32'(exp_q.size()), 32'd0);

        // zero count: exhausted within two cycles, no issue
        s0 = start_log.size();
        do_start(32'h100, 32'd0, 32'h1);
        check("z_exh_cleared", 32'(exhausted), 32'd0);
        step();
        check("z_exhausted", 32'(exhausted), 32'd1);
        check("z_busy", 32'(busy), 32'd0);
        repeat (5) step();
        check("z_starts", 32'(start_log.size() - s0), 32'd0);

        // abort coincident with a matching core_done
        begin
            int n = 0;
            match_nonce = 32'h40;
            exp_q.push_back(32'h40);
            do_start(32'h40, 32'd2, 32'h1357_9BDF);
            while (!bus.core_done && n < 50) begin
                step();
                n++;
            end
            check("a_done_seen", 32'(bus.core_done), 32'd1);
            cmd_abort = 1'b1;
            step();
            cmd_abort = 1'b0;
            check("a_busy", 32'(busy), 32'd0);
            repeat (3) step();
            check("a_found", 32'(found), 32'd0);
            check("a_exhausted", 32'(exhausted), 32'd0);
            check("a_sb_drained", 32'(exp_q.size()), 32'd0);
        end

        // lose lock during WAIT_DONE: same nonce reissued, count preserved
        match_nonce = 32'hDEAD_0000;
        lat_cfg     = 6;
        s0 = start_log.size();
        exp_q.push_back(32'h80); exp_q.push_back(32'h80);
        exp_q.push_back(32'h81); exp_q.push_back(32'h82);
        do_start(32'h80, 32'd3, 32'h2468_ACE0);
        wait_starts(s0 + 1, 20);
        repeat (2) step();
        pll_locked = 1'b0;
        repeat (2) step();
        check("l_status_led", 32'(status_led), 32'b00010);
        repeat (3) step();
        pll_locked = 1'b1;
        wait_idle(300);
        check("l_exhausted", 32'(exhausted), 32'd1);
        check("l_starts", 32'(start_log.size() - s0), 32'd4);
        check("l_sb_drained", 32'(exp_q.size()), 32'd0);
        lat_cfg = LAT;

        // cmd_start while searching is ignored
        pll_locked = 1'b0;
        s0 = start_log.size();
        exp_q.push_back(32'h200);
        do_start(32'h200, 32'd1, 32'h1111_2222);
        repeat (3) step();
        check("i_busy_wait_lock", 32'(busy), 32'd1);
        nonce_base  = 32'h300;
        nonce_count = 32'd5;
        cmd_start   = 1'b1;
        step();
        cmd_start   = 1'b0;
        pll_locked  = 1'b1;
        wait_idle(200);
        check("i_exhausted", 32'(exhausted), 32'd1);
        check("i_starts", 32'(start_log.size() - s0), 32'd1);
        check("i_sb_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-search; late matching core_done must be ignored
        match_nonce = 32'h33;
        s0 = start_log.size();
        exp_q.push_back(32'h33);
        do_start(32'h33, 32'd2, 32'h7777_8888);
        wait_starts(s0 + 1, 20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r_busy", 32'(busy), 32'd0);
        check("r_core_nonce", bus.core_nonce, 32'd0);
        repeat (10) step();
        check("r_found", 32'(found), 32'd0);
        check("r_starts", 32'(start_log.size() - s0), 32'd1);

`ifdef HASH_SEARCH_TIMEOUT_EN
        // silent core: watchdog reissues the same nonce every 10 cycles
        core_alive = 1'b0;
        s0 = start_log.size();
        exp_q.push_back(32'h5); exp_q.push_back(32'h5); exp_q.push_back(32'h5);
        do_start(32'h5, 32'd1, 32'h9999_0000);
        wait_starts(s0 + 3, 100);
        for (int i = s0 + 1; i < start_log.size(); i++)
            check("t_issue_gap", 32'(start_log[i] - start_log[i-1]), 32'd10);
        check("t_timeout_err", 32'(timeout_err), 32'd1);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        check("t_busy", 32'(busy), 32'd0);
        check("t_sb_drained", 32'(exp_q.size()), 32'd0);
        core_alive = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hash_search_ctrl.md
HASH_SEARCH_CTRL -- requirements
Module: hash_search_ctrl

Interface
REQ-001 SHALL have parameter NONCE_W, default 32, nonce width in bits.
REQ-002 SHALL have parameter DIGEST_W, default 32, compared digest width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, core watchdog limit; used only with HASH_SEARCH_TIMEOUT_EN.
REQ-004 SHALL have port clk_50, input, 1, sole clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pll_locked, input, 1, high when the hash core clock is valid.
REQ-007 SHALL have port cmd_start, input, 1, one-cycle pulse that starts a search.
REQ-008 SHALL have port cmd_abort, input, 1, one-cycle pulse that ends a search.
REQ-009 SHALL have port nonce_base, input, NONCE_W, first candidate nonce.
REQ-010 SHALL have port nonce_count, input, NONCE_W, number of candidates to try.
REQ-011 SHALL have port target, input, DIGEST_W, digest value to match.
REQ-012 SHALL have port core_start, output, 1, one-cycle start pulse to the hash core.
REQ-013 SHALL have port core_nonce, output, NONCE_W, candidate nonce presented to the core.
REQ-014 SHALL have port core_done, input, 1, one-cycle pulse that marks core_digest valid.
REQ-015 SHALL have port core_digest, input, DIGEST_W, core result.
REQ-016 SHALL have port busy, output, 1, high while a search is active.
REQ-017 SHALL have port found, output, 1, sticky match flag.
REQ-018 SHALL have port found_nonce, output, NONCE_W, nonce that matched.
REQ-019 SHALL have port exhausted, output, 1, sticky flag set when no candidate matched.
REQ-020 SHALL have port status_led, output, 5, status bits, active-high.

Function
REQ-021 SHALL implement the states IDLE, WAIT_LOCK, ISSUE, WAIT_DONE, CHECK, FOUND and EXHAUSTED.
REQ-022 IDLE with cmd_start SHALL latch nonce_base, nonce_count and target, clear found and exhausted, and enter WAIT_LOCK.
REQ-023 cmd_start SHALL be ignored in any state other than IDLE, FOUND or EXHAUSTED.
REQ-024 FOUND and EXHAUSTED SHALL behave as IDLE for cmd_start.
REQ-025 WAIT_LOCK SHALL enter ISSUE on the first cycle that pll_locked is high.
REQ-026 ISSUE SHALL drive core_start high for exactly one cycle, hold core_nonce stable until CHECK, and go to WAIT_DONE.
REQ-027 WAIT_DONE SHALL go to CHECK on the cycle after core_done is sampled high, and SHALL register core_digest on that core_done cycle.
REQ-028 CHECK with a registered digest equal to target SHALL set found, load found_nonce with the current nonce, and enter FOUND.
REQ-029 CHECK with no match SHALL decrement the remaining count; when it reaches 0 it SHALL set exhausted and enter EXHAUSTED, otherwise it SHALL increment the nonce and return to ISSUE.
REQ-030 The nonce SHALL increment modulo 2^NONCE_W, so all-ones wraps to 0 and the search continues.
REQ-031 A nonce_count of 0 at start SHALL give exhausted=1 within 2 cycles, with no core_start.
REQ-032 Issue-to-issue spacing SHALL be the core latency plus 3 cycles.
REQ-033 cmd_abort in any state except IDLE SHALL return the block to IDLE next cycle without setting found or exhausted; abort SHALL take priority over a coincident core_done or match.
REQ-034 pll_locked falling during ISSUE, WAIT_DONE or CHECK SHALL discard the in-flight result and return to WAIT_LOCK, keeping the current nonce and count.
REQ-035 busy SHALL be high in WAIT_LOCK, ISSUE, WAIT_DONE and CHECK.
REQ-036 status_led SHALL be {pll_locked, exhausted, found, busy, heartbeat}, where heartbeat toggles every 2^24 cycles.
REQ-037 A core_done that arrives outside WAIT_DONE SHALL be ignored.

Reset
REQ-038 reset SHALL force IDLE and drive core_start, busy, found, exhausted, found_nonce, core_nonce and the heartbeat counter to 0.
REQ-039 reset SHALL take priority over all other inputs, including during an active search.

Configuration
REQ-040 With HASH_SEARCH_TIMEOUT_EN defined, WAIT_DONE SHALL count cycles and, after TIMEOUT_CYCLES cycles with no core_done, SHALL re-enter ISSUE with the same nonce.
REQ-041 With HASH_SEARCH_TIMEOUT_EN defined, the block SHALL provide output timeout_err (1 bit), a sticky flag cleared by cmd_start or reset.
REQ-042 Without HASH_SEARCH_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, the timeout_err port SHALL not exist, and no watchdog logic SHALL be built.

Verification
REQ-043 Start with base=0x10, count=4 and a core model whose digest equals target at nonce 0x12 -> exactly 3 core_start pulses, found=1, found_nonce=0x12, busy=0.
REQ-044 Start with base=0xFFFFFFFE, count=3 and no match -> core_nonce sequence FFFFFFFE, FFFFFFFF, 00000000, then exhausted=1.
REQ-045 Start with count=0 -> exhausted=1 within 2 cycles, no core_start.
REQ-046 Abort in the same cycle as a matching core_done -> IDLE, found=0, exhausted=0.
REQ-047 Drop pll_locked for 5 cycles during WAIT_DONE -> the same nonce is reissued after relock, with no lost or duplicate count.
REQ-048 With HASH_SEARCH_TIMEOUT_EN, TIMEOUT_CYCLES=8 and a core that never answers -> core_start is reissued every 10 cycles and timeout_err=1.
